sync_fifo_wr_arb: RTL

Round-robin write arbiter that shares one sync_fifo write port between NUM_REQ event sources, e.g. pixel-row readout channels.
- Accepts words over per-requester valid/ready handshakes.
- Registers the winning word onto the FIFO write port.
- Tracks FIFO occupancy plus the in-flight write, so the FIFO never sees wr_en while it has no free slot.
- Sits directly in front of sync_fifo; the FIFO read side is untouched.

---
 rtl/sync_fifo_wr_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter in front of a sync_fifo write port.
// Optional per-requester accept counters: define ARB_STATS_EN.
module sync_fifo_wr_arb #(
  parameter int NUM_REQ     = 4,
  parameter int FIFO_DWIDTH = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           arb_en,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*FIFO_DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  input  logic [$clog2(FIFO_DEPTH):0]    fifo_numel,
  output logic                           fifo_wr_en,
  output logic [FIFO_DWIDTH-1:0]         fifo_data_in,
  output logic                           busy,
  input  logic [$clog2(NUM_REQ)-1:0]     stat_sel,
  output logic [15:0]                    stat_cnt
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(FIFO_DEPTH) + 2;
  localparam logic [SW-1:0] DEPTH_V = SW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            nstate;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic [PW-1:0]     ptr_next;
  logic              found;
  logic              any_valid;
  logic              credit_ok;
  logic              xfer;
  logic [SW-1:0]     sum;
  logic [NUM_REQ-1:0] grant_oh;
  logic              unused_state;

  assign any_valid = |req_valid;

  // The registered write is in flight and not yet counted in numel.
  assign sum = SW'(fifo_numel) + SW'(fifo_wr_en);
  assign credit_ok = !fifo_full && (sum < DEPTH_V);

  // Next state drives grants directly; reset forces IDLE so ready drops at once.
  always_comb begin
    nstate = IDLE;
    if (!rst_n || !arb_en || !any_valid) begin
      nstate = IDLE;
    end else if (credit_ok) begin
      nstate = GRANT;
    end else begin
      nstate = HOLD;
    end
  end

  // Scan upward from the pointer for the first valid requester.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign grant_oh = found ? (NUM_REQ'(1) << win) : '0;
  assign req_ready = (nstate == GRANT) ? grant_oh : '0;
  assign xfer = |(req_valid & req_ready);

  assign ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

  // Write port, pointer advance and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr          <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      busy         <= 1'b0;
    end else begin
      state_q    <= nstate;
      fifo_wr_en <= xfer;
      busy       <= (nstate != IDLE) || xfer;
      if (xfer) begin
        fifo_data_in <= req_data[int'(win)*FIFO_DWIDTH +: FIFO_DWIDTH];
        ptr          <= ptr_next;
      end
    end
  end

  assign unused_state = ^state_q;

`ifdef ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];

  // Saturating accept counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (xfer && (cnt[win] != 16'hFFFF)) begin
      cnt[win] <= cnt[win] + 16'd1;
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    stat_cnt = '0;
    if (int'(stat_sel) < NUM_REQ) stat_cnt = cnt[stat_sel];
  end
`else
  logic unused_sel;
  assign unused_sel = ^stat_sel;
  assign stat_cnt = 16'h0;
`endif

endmodule
